// File: rtl/result_drain_if.sv
// Handshake and strobe bundle between the result drain controller and its
// neighbours (MAC units, downstream consumer, sequencing controller).
interface result_drain_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic              start;
    logic              mac1_valid;
    logic [DATA_W-1:0] mac1_data;
    logic              mac2_valid;
    logic [DATA_W-1:0] mac2_data;
    logic              dout_ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_last;
    logic [IDX_W-1:0]  final_mux_sel;
    logic              mem_clr;
    logic              output_clr;
    logic              output_set;
    logic              busy;
    logic              err;

    // Environment side: sequencer, MAC units and consumer
    modport master (
        output start, mac1_valid, mac1_data, mac2_valid, mac2_data, dout_ready,
        input  dout, dout_valid, dout_last, final_mux_sel,
        input  mem_clr, output_clr, output_set, busy, err
    );

    // Controller side
    modport slave (
        input  start, mac1_valid, mac1_data, mac2_valid, mac2_data, dout_ready,
        output dout, dout_valid, dout_last, final_mux_sel,
        output mem_clr, output_clr, output_set, busy, err
    );
endinterface

// File: rtl/result_drain_ctrl.sv
// Captures MAC results into a ROWS x COLS buffer, then streams them out over valid/ready.
// Define RESULT_TRANSPOSE_EN to drain in column-major order instead of row-major.
module result_drain_ctrl #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 3,
    parameter int COLS   = 4,
    parameter int IDX_W  = 4
) (
    input  logic          clk,
    input  logic          reset,
    result_drain_if.slave bus
);
    localparam int NUM_RESULTS = ROWS * COLS;
    localparam int WP_W        = IDX_W + 1;   // must also hold the "full" count
    localparam logic [WP_W-1:0]  NUM_WP   = WP_W'(NUM_RESULTS);
    localparam logic [WP_W-1:0]  WP_ONE   = WP_W'(1);
    localparam logic [WP_W-1:0]  WP_TWO   = WP_W'(2);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WP_W-1:0]   wp_q, wp_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [NUM_RESULTS];

    logic              we0, we1;
    logic [IDX_W-1:0]  wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;

    logic [IDX_W-1:0]  rd_sel;
    logic              rd_last;
    logic              rd_advance;

    assign rd_advance = (state_q == DRAIN) && bus.dout_ready;

`ifdef RESULT_TRANSPOSE_EN
    localparam logic [IDX_W-1:0] R_LAST = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(COLS - 1);
    logic [IDX_W-1:0] r_q, r_d, c_q, c_d;

    // Rows advance fastest so consecutive outputs walk down a column
    assign rd_sel  = IDX_W'(int'(r_q) * COLS + int'(c_q));
    assign rd_last = (r_q == R_LAST) && (c_q == C_LAST);

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (state_q == CLEAR) begin
            r_d = '0;
            c_d = '0;
        end else if (rd_advance && !rd_last) begin
            if (r_q == R_LAST) begin
                r_d = '0;
                c_d = c_q + IDX_ONE;
            end else begin
                r_d = r_q + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end
`else
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_RESULTS - 1);
    logic [IDX_W-1:0] k_q, k_d;

    assign rd_sel  = k_q;
    assign rd_last = (k_q == K_LAST);

    always_comb begin
        k_d = k_q;
        if (state_q == CLEAR) begin
            k_d = '0;
        end else if (rd_advance && !rd_last) begin
            k_d = k_q + IDX_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        err_d   = err_q;
        we0     = 1'b0;
        we1     = 1'b0;
        wa0     = wp_q[IDX_W-1:0];
        wa1     = wp_q[IDX_W-1:0] + IDX_ONE;
        wd0     = bus.mac1_data;
        wd1     = bus.mac2_data;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                wp_d    = '0;
                err_d   = 1'b0;
                state_d = COLLECT;
            end
            COLLECT: begin
                if (bus.mac1_valid && bus.mac2_valid) begin
                    we0 = 1'b1;
                    // Only one slot left: MAC1 wins, MAC2 is lost and flagged
                    if (wp_q == NUM_WP - WP_ONE) begin
                        err_d = 1'b1;
                        wp_d  = wp_q + WP_ONE;
                    end else begin
                        we1  = 1'b1;
                        wp_d = wp_q + WP_TWO;
                    end
                end else if (bus.mac1_valid) begin
                    we0  = 1'b1;
                    wp_d = wp_q + WP_ONE;
                end else if (bus.mac2_valid) begin
                    we0  = 1'b1;
                    wd0  = bus.mac2_data;
                    wp_d = wp_q + WP_ONE;
                end
                if (wp_d == NUM_WP) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.mac1_valid || bus.mac2_valid) err_d = 1'b1;
                if (bus.dout_ready && rd_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            err_q   <= err_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (we0) mem_q[wa0] <= wd0;
        if (we1) mem_q[wa1] <= wd1;
    end

    assign bus.dout_valid    = (state_q == DRAIN);
    assign bus.final_mux_sel = bus.dout_valid ? rd_sel : '0;
    assign bus.dout          = bus.dout_valid ? mem_q[rd_sel] : '0;
    assign bus.dout_last     = bus.dout_valid && rd_last;
    assign bus.mem_clr       = (state_q == CLEAR);
    assign bus.output_clr    = (state_q == CLEAR);
    assign bus.output_set    = (state_q == DONE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.err           = err_q;
endmodule

// File: tb/tb_result_drain_ctrl.sv
// Self-checking bench for result_drain_ctrl: scenario table plus hand-written
// reset/idle sequences, with a scoreboard of expected drain outputs.
module tb_result_drain_ctrl;
    localparam int DATA_W = 16;
    localparam int ROWS   = 3;
    localparam int COLS   = 4;
    localparam int IDX_W  = 4;
    localparam int NUM    = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    result_drain_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    result_drain_ctrl #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  sel;
        logic              last;
    } exp_t;

    typedef struct {
        int                mode;        // 0 mac1, 1 mac2, 2 both, 3 overflow, 4 mixed
        int                ready_mode;  // 0 always, 1 toggle pattern, 2 random
        logic              exp_err;
        logic [DATA_W-1:0] base;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [DATA_W-1:0] mbuf [NUM];
    bit   pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"},       32'(bus.dout), 0);
        chk({tag, "_dout_valid"}, 32'(bus.dout_valid), 0);
        chk({tag, "_dout_last"},  32'(bus.dout_last), 0);
        chk({tag, "_sel"},        32'(bus.final_mux_sel), 0);
        chk({tag, "_mem_clr"},    32'(bus.mem_clr), 0);
        chk({tag, "_output_clr"}, 32'(bus.output_clr), 0);
        chk({tag, "_output_set"}, 32'(bus.output_set), 0);
        chk({tag, "_busy"},       32'(bus.busy), 0);
        chk({tag, "_err"},        32'(bus.err), 0);
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.mac1_valid = 1'b0;
        bus.mac1_data  = '0;
        bus.mac2_valid = 1'b0;
        bus.mac2_data  = '0;
        bus.dout_ready = 1'b0;
    endtask

    function automatic int drain_idx(input int k);
`ifdef RESULT_TRANSPOSE_EN
        return (k % ROWS) * COLS + (k / ROWS);
`else
        return k;
`endif
    endfunction

    task automatic run_product(input int mode, input int ready_mode, input logic exp_err,
                               input int abort_after, input logic [DATA_W-1:0] base);
        int   wp;
        int   cyc;
        int   xfers;
        int   idx;
        logic v1, v2, rdy;
        logic [DATA_W-1:0] d1, d2;
        exp_t e;

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("clear_mem_clr",    32'(bus.mem_clr), 1);
        chk("clear_output_clr", 32'(bus.output_clr), 1);
        chk("clear_busy",       32'(bus.busy), 1);

        wp  = 0;
        cyc = 0;
        while (wp < NUM && cyc < 100) begin
            @(negedge clk);
            bus.mac1_valid = 1'b0;
            bus.mac2_valid = 1'b0;
            if (cyc == 0) begin
                chk("collect_err_cleared", 32'(bus.err), 0);
                chk("collect_mem_clr_low", 32'(bus.mem_clr), 0);
            end
            chk("collect_no_valid", 32'(bus.dout_valid), 0);
            v1 = 1'b0;
            v2 = 1'b0;
            d1 = DATA_W'(int'(base) + wp);
            d2 = DATA_W'(int'(base) + wp);
            case (mode)
                0: v1 = 1'b1;
                1: v2 = 1'b1;
                2: begin v1 = 1'b1; v2 = 1'b1; d2 = DATA_W'(int'(base) + wp + 1); end
                3: begin
                    v1 = 1'b1;
                    if (wp == NUM - 1) begin
                        v2 = 1'b1;
                        d1 = 16'hAAAA;
                        d2 = 16'hBBBB;
                    end
                end
                default: begin
                    case (cyc % 4)
                        0: v1 = 1'b1;
                        1: begin
                            v1 = 1'b1;
                            if (wp <= NUM - 2) begin
                                v2 = 1'b1;
                                d2 = DATA_W'(int'(base) + wp + 1);
                            end
                        end
                        2: ;
                        default: v2 = 1'b1;
                    endcase
                end
            endcase
            if (v1 && v2) begin
                mbuf[wp] = d1;
                if (wp + 1 < NUM) begin
                    mbuf[wp + 1] = d2;
                    wp += 2;
                end else begin
                    wp += 1;
                end
            end else if (v1) begin
                mbuf[wp] = d1;
                wp += 1;
            end else if (v2) begin
                mbuf[wp] = d2;
                wp += 1;
            end
            bus.mac1_valid = v1;
            bus.mac1_data  = d1;
            bus.mac2_valid = v2;
            bus.mac2_data  = d2;
            cyc++;
        end

        for (int k = 0; k < NUM; k++) begin
            idx    = drain_idx(k);
            e.data = mbuf[idx];
            e.sel  = IDX_W'(idx);
            e.last = (k == NUM - 1);
            sb.push_back(e);
        end

        xfers = 0;
        cyc   = 0;
        while (sb.size() > 0 && cyc < 200) begin
            @(negedge clk);
            bus.mac1_valid = 1'b0;
            bus.mac2_valid = 1'b0;
            bus.start      = 1'b0;
            if (abort_after > 0 && xfers == abort_after) begin
                chk("abort_mid_drain", 32'(bus.dout_valid), 1);
                reset = 1'b1;
                #1;
                chk_zero("abort");
                @(negedge clk);
                reset = 1'b0;
                bus.dout_ready = 1'b0;
                sb.delete();
                return;
            end
            chk(cyc == 0 ? "drain_latency" : "drain_valid", 32'(bus.dout_valid), 1);
            if (cyc == 0 && mode == 3) chk("overflow_err", 32'(bus.err), 1);
            e = sb[0];
            chk("dout", 32'(bus.dout), 32'(e.data));
            chk("sel",  32'(bus.final_mux_sel), 32'(e.sel));
            chk("last", 32'(bus.dout_last), 32'(e.last));
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 5];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.dout_ready = rdy;
            if (mode == 4 && cyc == 3) begin
                bus.mac1_valid = 1'b1;
                bus.start      = 1'b1;
            end
            if (rdy) begin
                $display("tx %0d: dout=%h sel=%0d last=%0b", xfers, bus.dout,
                         bus.final_mux_sel, bus.dout_last);
                void'(sb.pop_front());
                xfers++;
            end
            cyc++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end

        @(negedge clk);
        bus.dout_ready = 1'b0;
        bus.mac1_valid = 1'b0;
        bus.start      = 1'b0;
        chk("xfer_count",     32'(xfers), NUM);
        chk("done_set",       32'(bus.output_set), 1);
        chk("done_valid",     32'(bus.dout_valid), 0);
        chk("done_busy",      32'(bus.busy), 1);
        @(negedge clk);
        chk("idle_busy",      32'(bus.busy), 0);
        chk("idle_set",       32'(bus.output_set), 0);
        chk("idle_err",       32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [7];
        vecs[0] = '{mode: 0, ready_mode: 0, exp_err: 1'b0, base: 16'h0001};
        vecs[1] = '{mode: 2, ready_mode: 0, exp_err: 1'b0, base: 16'h0001};
        vecs[2] = '{mode: 0, ready_mode: 1, exp_err: 1'b0, base: 16'h0100};
        vecs[3] = '{mode: 3, ready_mode: 0, exp_err: 1'b1, base: 16'h0200};
        vecs[4] = '{mode: 0, ready_mode: 0, exp_err: 1'b0, base: 16'h0300};
        vecs[5] = '{mode: 1, ready_mode: 2, exp_err: 1'b0, base: 16'h0400};
        vecs[6] = '{mode: 4, ready_mode: 1, exp_err: 1'b1, base: 16'h0500};

        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // MAC activity while idle must neither start anything nor raise err
        @(negedge clk);
        bus.mac1_valid = 1'b1;
        bus.mac2_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.mac1_valid = 1'b0;
        bus.mac2_valid = 1'b0;
        @(negedge clk);
        chk("idle_mac_busy", 32'(bus.busy), 0);
        chk("idle_mac_err",  32'(bus.err), 0);

        for (int i = 0; i < 7; i++) begin
            run_product(vecs[i].mode, vecs[i].ready_mode, vecs[i].exp_err, 0, vecs[i].base);
        end

        // Abort after five transfers, then a clean product must follow
        run_product(0, 0, 1'b0, 5, 16'h0600);
        run_product(0, 0, 1'b0, 0, 16'h0700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
